// File: rtl/sfc_pkg.sv
// Shared types and helpers for the serial frame checker.
// Holds the FSM state enum, mode encodings and a saturating increment.
package sfc_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam logic MODE_FRAME   = 1'b0;
    localparam logic MODE_PATTERN = 1'b1;

    // Increment v by one unless it already sits at top.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input logic [31:0] top
    );
        return (v >= top) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sfc_sat_counter.sv
// Saturating event counter; sticks at all-ones, never wraps.
// Ports: clock, clear (sync, highest priority), inc, count[WIDTH-1:0].
module sfc_sat_counter
    import sfc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [31:0] TOP = 32'({WIDTH{1'b1}});

    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= WIDTH'(sat_inc(32'(count), TOP));
        end
    end

endmodule

// File: rtl/serial_frame_checker.sv
// Serial bit-stream checker: W-bit frame range check (MODE=0) or
// sliding-window pattern match (MODE=1), with a saturating hit count.
// Ports: clock, RESET_G (sync, active high), LINEA/LINEA_VALID serial
// input (MSB first), MODE, PAT_LOAD/PAT_IN pattern load, U_REG hit
// pulse, FRAME_DONE frame pulse, ERR_CNT saturating hit count.
module serial_frame_checker
    import sfc_pkg::*;
#(
    parameter int          W           = 4,
    parameter int unsigned MAX_VAL     = 9,
    parameter logic [W-1:0] DEF_PATTERN = W'(4'b1011),
    parameter int          OVERLAP     = 1,
    parameter int          CNT_W       = 8
) (
    input  logic             clock,
    input  logic             RESET_G,
    input  logic             LINEA,
    input  logic             LINEA_VALID,
    input  logic             MODE,
    input  logic             PAT_LOAD,
    input  logic [W-1:0]     PAT_IN,
    output logic             U_REG,
    output logic             FRAME_DONE,
    output logic [CNT_W-1:0] ERR_CNT
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state, state_n;
    logic [W-1:0]  sr, sr_n;
    logic [W-1:0]  pattern, pattern_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          mode_q;
    logic          u_n, fd_n;
    logic [W-1:0]  window;
    logic          armed_n;

    assign window = {sr[W-2:0], LINEA};

    always_ff @(posedge clock) begin
        if (RESET_G) begin
            state      <= FILL;
            sr         <= '0;
            pattern    <= DEF_PATTERN;
            cnt        <= '0;
            mode_q     <= MODE;
            U_REG      <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            state      <= state_n;
            sr         <= sr_n;
            pattern    <= pattern_n;
            cnt        <= cnt_n;
            mode_q     <= MODE;
            U_REG      <= u_n;
            FRAME_DONE <= fd_n;
        end
    end

    always_comb begin
        state_n   = state;
        sr_n      = sr;
        pattern_n = pattern;
        cnt_n     = cnt;
        u_n       = 1'b0;
        fd_n      = 1'b0;
        armed_n   = 1'b0;

        if (MODE != mode_q) begin
            // Mode switch: restart the window, drop this cycle's bit.
            sr_n    = '0;
            cnt_n   = '0;
            state_n = FILL;
            if (PAT_LOAD) begin
                pattern_n = PAT_IN;
            end
        end else if (PAT_LOAD) begin
            pattern_n = PAT_IN;
            cnt_n     = '0;
            state_n   = FILL;
        end else if (LINEA_VALID) begin
            sr_n = window;
            if (mode_q == MODE_FRAME) begin
                state_n = FILL;
                if (cnt == LAST) begin
                    cnt_n = '0;
                    fd_n  = 1'b1;
                    u_n   = 32'(window) > MAX_VAL;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end else begin
                // Window is full once ARMED or on the W-th fill bit.
                armed_n = (state == ARMED) || (cnt == LAST);
                if (armed_n) begin
                    state_n = ARMED;
                    cnt_n   = LAST;
                    if (window == pattern) begin
                        u_n = 1'b1;
                        if (OVERLAP == 0) begin
                            cnt_n   = '0;
                            state_n = FILL;
                        end
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
        end
    end

    // Counter steps on the same edge that raises U_REG.
    sfc_sat_counter #(
        .WIDTH(CNT_W)
    ) u_cnt (
        .clock(clock),
        .clear(RESET_G),
        .inc  (u_n & ~RESET_G),
        .count(ERR_CNT)
    );

endmodule

// File: tb/tb_serial_frame_checker.sv
// Testbench for serial_frame_checker: three instances (default,
// OVERLAP=0, CNT_W=2) share one stimulus stream.
module tb_serial_frame_checker;

    typedef struct {
        logic       rst;
        logic       mode;
        logic       vld;
        logic       lin;
        logic       ld;
        logic [3:0] pat;
        logic       eu;
        logic       efd;
        logic       eu0;
    } vec_t;

    typedef struct {
        logic       eu;
        logic       efd;
        logic       eu0;
        logic [7:0] ec;
        logic [7:0] ec0;
        logic [1:0] ecs;
    } exp_t;

    logic       clock = 1'b0;
    logic       rst_g = 1'b0;
    logic       lin = 1'b0;
    logic       lin_vld = 1'b0;
    logic       mode = 1'b0;
    logic       pat_ld = 1'b0;
    logic [3:0] pat_in = 4'd0;

    logic       u_a, fd_a;
    logic [7:0] cnt_a;
    logic       u_b, fd_b;
    logic [7:0] cnt_b;
    logic       u_c, fd_c;
    logic [1:0] cnt_c;

    int tests = 0;
    int fails = 0;
    int step = 0;

    logic [7:0] m_ec = 0;
    logic [7:0] m_ec0 = 0;
    logic [1:0] m_ecs = 0;

    exp_t sb[$];
    vec_t tbl[$];

    always #5 clock = ~clock;

    serial_frame_checker dut_a (
        .clock(clock), .RESET_G(rst_g), .LINEA(lin),
        .LINEA_VALID(lin_vld), .MODE(mode), .PAT_LOAD(pat_ld),
        .PAT_IN(pat_in), .U_REG(u_a), .FRAME_DONE(fd_a),
        .ERR_CNT(cnt_a)
    );

    serial_frame_checker #(.OVERLAP(0)) dut_b (
        .clock(clock), .RESET_G(rst_g), .LINEA(lin),
        .LINEA_VALID(lin_vld), .MODE(mode), .PAT_LOAD(pat_ld),
        .PAT_IN(pat_in), .U_REG(u_b), .FRAME_DONE(fd_b),
        .ERR_CNT(cnt_b)
    );

    serial_frame_checker #(.CNT_W(2)) dut_c (
        .clock(clock), .RESET_G(rst_g), .LINEA(lin),
        .LINEA_VALID(lin_vld), .MODE(mode), .PAT_LOAD(pat_ld),
        .PAT_IN(pat_in), .U_REG(u_c), .FRAME_DONE(fd_c),
        .ERR_CNT(cnt_c)
    );

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %0d expected %0d",
                     nm, step, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        exp_t g;
        rst_g   = v.rst;
        mode    = v.mode;
        lin_vld = v.vld;
        lin     = v.lin;
        pat_ld  = v.ld;
        pat_in  = v.pat;
        @(posedge clock);
        if (v.rst) begin
            m_ec = 0; m_ec0 = 0; m_ecs = 0;
        end else begin
            if (v.eu) begin
                m_ec = m_ec + 8'd1;
                if (m_ecs != 2'd3) m_ecs = m_ecs + 2'd1;
            end
            if (v.eu0) m_ec0 = m_ec0 + 8'd1;
        end
        e.eu = v.eu; e.efd = v.efd; e.eu0 = v.eu0;
        e.ec = m_ec; e.ec0 = m_ec0; e.ecs = m_ecs;
        sb.push_back(e);
        @(negedge clock);
        g = sb.pop_front();
        chk("u_reg",      {7'd0, u_a},  {7'd0, g.eu});
        chk("frame_done", {7'd0, fd_a}, {7'd0, g.efd});
        chk("err_cnt",    cnt_a,        g.ec);
        chk("u_reg_ovl0", {7'd0, u_b},  {7'd0, g.eu0});
        chk("err_cnt_ovl0", cnt_b,      g.ec0);
        chk("fd_sat",     {7'd0, fd_c}, {7'd0, g.efd});
        chk("err_cnt_sat", {6'd0, cnt_c}, {6'd0, g.ecs});
        step++;
    endtask

    function automatic vec_t mk(input logic r, input logic m,
        input logic vd, input logic b, input logic l,
        input logic [3:0] p, input logic u, input logic f,
        input logic u0);
        vec_t v;
        v.rst = r; v.mode = m; v.vld = vd; v.lin = b; v.ld = l;
        v.pat = p; v.eu = u; v.efd = f; v.eu0 = u0;
        return v;
    endfunction

    // Frame-mode valid bit.
    task automatic fbit(input logic b, input logic u, input logic f);
        apply(mk(0, 0, 1, b, 0, 4'd0, u, f, u));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(mk(0, 0, 0, 0, 0, 4'd0, 0, 0, 0));
    endtask

    initial begin
        // reset, frame 1010 (bad), frame 1001 (good)
        tbl.push_back(mk(1, 0, 0, 0, 0, 4'd0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 4'd0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 4'd0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 4'd0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 4'd0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0, 4'd0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 4'd0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 4'd0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 4'd0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'd0, 0, 0, 0));
        // switch to pattern mode; bit this cycle is ignored
        tbl.push_back(mk(0, 1, 1, 1, 0, 4'd0, 0, 0, 0));
        // stream 1,0,1,1,0,1,1 against 1011
        tbl.push_back(mk(0, 1, 1, 1, 0, 4'd0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 4'd0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 4'd0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 4'd0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 4'd0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 4'd0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 4'd0, 1, 0, 0));
        // load 0110 with a valid bit in the same cycle (dropped)
        tbl.push_back(mk(0, 1, 1, 1, 1, 4'b0110, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 4'd0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 4'd0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 4'd0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 4'd0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 4'd0, 0, 0, 0));

        @(negedge clock);
        foreach (tbl[i]) apply(tbl[i]);

        // back to frame mode, then frame 1100 with 3-cycle gaps
        idle(1);
        fbit(1, 0, 0); idle(3);
        fbit(1, 0, 0); idle(3);
        fbit(0, 0, 0); idle(3);
        fbit(0, 1, 1);

        // reset mid-frame: reset wins over a valid bit
        fbit(1, 0, 0);
        fbit(1, 0, 0);
        apply(mk(1, 0, 1, 1, 0, 4'd0, 0, 0, 0));
        fbit(1, 0, 0);
        fbit(0, 0, 0);
        fbit(0, 0, 0);
        fbit(1, 0, 1);

        // five back-to-back bad frames; CNT_W=2 copy saturates at 3
        for (int f = 0; f < 5; f++) begin
            fbit(1, 0, 0);
            fbit(1, 0, 0);
            fbit(1, 0, 0);
            fbit(1, 1, 1);
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
